// File: rtl/layer_sequencer.sv
// layer_sequencer: runs the LeNet-5 layer blocks one at a time, with a guard gap, a watchdog and abort.
// Optional SEQ_PERF_CNT_EN: latch the busy-cycle count of each completed inference on total_cycles.
module layer_sequencer #(
  parameter int NUM_LAYERS  = 5,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 500000,
  parameter int GAP_CYC     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            cur_layer,
  output logic [2:0]            err_layer,
  output logic [31:0]           total_cycles
);
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_FINISH, S_ERR} state_t;

  state_t                r_state;
  logic [NUM_LAYERS-1:0] r_en;
  logic                  r_busy, r_done, r_error;
  logic [2:0]            r_cur, r_err_layer;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic [GAP_W-1:0]      r_gap;

  logic w_accept, w_cur_done, w_tmo, w_gap_ok, w_last, w_gap_exit;

  assign w_accept   = (r_state == S_IDLE || r_state == S_ERR) && start && !abort;
  assign w_cur_done = layer_done[r_cur[IDX_W-1:0]];
  assign w_tmo      = (r_wdog >= TIMEOUT_W'(TIMEOUT_CYC - 1));
  assign w_gap_ok   = (r_gap >= GAP_W'(GAP_CYC - 1));
  assign w_last     = (r_cur == 3'(NUM_LAYERS - 1));
  // A layer still holding done keeps us in GAP so its FSM is back in IDLE first
  assign w_gap_exit = (r_state == S_GAP) && !abort && w_gap_ok && !w_cur_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_en        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cur       <= '0;
      r_err_layer <= '0;
      r_wdog      <= '0;
      r_gap       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (w_accept) begin
            r_state     <= S_RUN;
            r_cur       <= '0;
            r_en        <= NUM_LAYERS'(1);
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
            r_err_layer <= '0;
            r_wdog      <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_en    <= '0;
            r_busy  <= 1'b0;
          end else if (w_cur_done) begin
            r_state <= S_GAP;
            r_en    <= '0;
            r_gap   <= '0;
            r_wdog  <= '0;
          end else if (w_tmo) begin
            r_state     <= S_ERR;
            r_en        <= '0;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_err_layer <= r_cur;
          end else begin
            r_wdog <= (&r_wdog) ? r_wdog : r_wdog + 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_gap_exit) begin
            if (w_last) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_cur   <= r_cur + 3'd1;
              r_en    <= NUM_LAYERS'(1) << (r_cur + 3'd1);
              r_wdog  <= '0;
            end
          end else if (w_tmo) begin
            r_state     <= S_ERR;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_err_layer <= r_cur;
          end else begin
            r_wdog <= (&r_wdog) ? r_wdog : r_wdog + 1'b1;
            r_gap  <= (&r_gap) ? r_gap : r_gap + 1'b1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf, r_total, w_perf_inc;
  assign w_perf_inc = (&r_perf) ? r_perf : r_perf + 32'd1;

  // The finishing cycle is still a busy cycle, so latch the incremented count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf  <= '0;
      r_total <= '0;
    end else begin
      if (w_accept)    r_perf <= '0;
      else if (r_busy) r_perf <= w_perf_inc;
      if (w_gap_exit && w_last) r_total <= w_perf_inc;
    end
  end
  assign total_cycles = r_total;
`else
  assign total_cycles = '0;
`endif

  assign layer_en  = r_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cur_layer = r_cur;
  assign err_layer = r_err_layer;
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: per-layer done models, expected enable/done/error event queue.
module tb_layer_sequencer;
  localparam int NL = 5, TMO = 100, GAP = 2, LAT = 20;

  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [NL-1:0] layer_en, mdone = '0, force_done = '0, nodone = '0;
  wire  [NL-1:0] layer_done = mdone | force_done;
  logic busy, done, error;
  logic [2:0] cur_layer, err_layer;
  logic [31:0] total_cycles;

  int n_chk = 0, n_err = 0, cyc = 0, st_cyc = 0;
  int sb[$];
  int ecnt[NL], hcnt[NL], hold[NL], rise_cyc[NL], gap_zeros[NL], dfall_cyc[NL];
  int zeros = 0, busy_cnt = 0, err_cyc = 0, midx = 0;
  longint exp_total = 0;
  logic [NL-1:0] prev_en = '0, rise;
  logic prev_busy = 0, prev_err = 0;

  layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_W(20), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer_done(layer_done),
    .layer_en(layer_en), .busy(busy), .done(done), .error(error),
    .cur_layer(cur_layer), .err_layer(err_layer), .total_cycles(total_cycles));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input int val);
    if (sb.size() == 0) chk(tag, val, 999);
    else chk(tag, val, sb.pop_front());
  endtask

  // Layer models: done rises LAT cycles after enable, falls hold[i] cycles after enable drops
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        mdone[i] = 1'b0; ecnt[i] = 0; hcnt[i] = 0;
      end else if (layer_en[i]) begin
        ecnt[i]++; hcnt[i] = 0;
        if (ecnt[i] >= LAT && !nodone[i]) mdone[i] = 1'b1;
      end else begin
        ecnt[i] = 0;
        if (mdone[i]) begin
          hcnt[i]++;
          if (hcnt[i] >= hold[i]) begin mdone[i] = 1'b0; dfall_cyc[i] = cyc; end
        end
      end
    end
  end

  // Output monitor: pops expected events as the DUT produces them
  always @(negedge clk) begin
    rise = layer_en & ~prev_en;
    if (rise != '0) begin
      for (int i = 0; i < NL; i++) if (rise[i]) midx = i;
      chk("en_onehot", $onehot(layer_en), 1);
      if (midx > 0) chk("gap_min", zeros >= GAP, 1);
      gap_zeros[midx] = zeros;
      rise_cyc[midx]  = cyc;
      sb_pop("en_order", midx);
    end
    if (layer_en == '0) zeros++; else zeros = 0;
    if (done) begin
      chk("done_busy_low", busy, 0);
`ifdef SEQ_PERF_CNT_EN
      exp_total = busy_cnt;
`endif
      chk("total_cycles", total_cycles, exp_total);
      sb_pop("done_evt", 100);
    end
    if (error && !prev_err) begin
      err_cyc = cyc;
      sb_pop("err_evt", 200 + int'(err_layer));
    end
    if (busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
    prev_en = layer_en; prev_busy = busy; prev_err = error;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic ab);
    start = 1'b1; abort = ab; st_cyc = cyc;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic push_run(input int last, input bit fin);
    for (int i = 0; i <= last; i++) sb.push_back(i);
    if (fin) sb.push_back(100);
  endtask

  function automatic bit sig(input int kind, input int arg);
    case (kind)
      0: return layer_en[arg];
      1: return done;
      2: return error;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int arg, input int max, input string tag);
    int n = 0;
    while (!sig(kind, arg) && n < max) begin tick(); n++; end
    if (!sig(kind, arg)) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"}, layer_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cur"}, cur_layer, 0);
    chk({tag, "_errl"}, err_layer, 0);
    chk({tag, "_total"}, total_cycles, 0);
  endtask

  initial begin
    for (int i = 0; i < NL; i++) hold[i] = 1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    // nominal inference, start at cycle 10
    while (cyc < 10) tick();
    push_run(4, 1);
    pulse_start(1'b0);
    wait_for(1, 0, 400, "nominal_done");
    chk("start_lat", rise_cyc[0], st_cyc + 1);
    chk("nominal_cur_last", cur_layer, 4);
    tick();
    chk("done_one_cycle", done, 0);
    chk("sb_nominal", sb.size(), 0);

    // sticky done on layer 2, plus start and layer_done[4] during layer 1
    hold[2] = 5;
    push_run(4, 1);
    pulse_start(1'b0);
    wait_for(0, 1, 100, "wait_l1");
    tick();
    pulse_start(1'b0);
    force_done[4] = 1'b1;
    repeat (5) tick();
    force_done[4] = 1'b0;
    chk("ign_l1_en", layer_en, 5'b00010);
    chk("ign_cur", cur_layer, 1);
    wait_for(1, 0, 600, "sticky_done");
    chk("sticky_l3_rise", rise_cyc[3], dfall_cyc[2] + 1);
    chk("sticky_gap_len", gap_zeros[3], 5);
    chk("sb_sticky", sb.size(), 0);
    hold[2] = 1;
    tick();

    // start and abort together in IDLE
    pulse_start(1'b1);
    repeat (3) tick();
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_en", layer_en, 0);

    // watchdog on layer 1
    nodone[1] = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(201);
    pulse_start(1'b0);
    wait_for(2, 0, 400, "wd_err");
    chk("wd_latency", err_cyc - rise_cyc[1], TMO);
    chk("wd_err_layer", err_layer, 1);
    chk("wd_en", layer_en, 0);
    chk("wd_busy", busy, 0);
    chk("wd_total_hold", total_cycles, exp_total);
    repeat (3) tick();
    chk("wd_sticky", error, 1);
    nodone[1] = 1'b0;
    push_run(4, 1);
    pulse_start(1'b0);
    chk("wd_clr_error", error, 0);
    chk("wd_clr_errl", err_layer, 0);
    chk("wd_restart_en", layer_en, 5'b00001);
    wait_for(1, 0, 400, "wd_rerun_done");
    chk("sb_wd", sb.size(), 0);
    tick();

    // abort during layer 3
    push_run(3, 0);
    pulse_start(1'b0);
    wait_for(0, 3, 400, "ab_l3");
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_en", layer_en, 0);
    chk("ab_busy", busy, 0);
    repeat (5) tick();
    chk("ab_total_hold", total_cycles, exp_total);
    chk("sb_abort", sb.size(), 0);

    // restart, then reset during layer 2
    push_run(2, 0);
    pulse_start(1'b0);
    chk("restart_en", layer_en, 5'b00001);
    chk("restart_cur", cur_layer, 0);
    wait_for(0, 2, 400, "rst_l2");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset("midrst");
    exp_total = 0;
    chk("sb_reset", sb.size(), 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
